// File: rtl/xcore_ifu_ibuf_if.sv
// Fetch-side and decode-side handshake bundle for the instruction fetch buffer.
interface xcore_ifu_ibuf_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_pc;
  logic [DW-1:0] in_instr;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_pc;
  logic [DW-1:0] out_instr;

  // Buffer side: consumes fetch entries, produces the head entry for decode.
  modport slave (
    input  in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr
  );

  // Environment side: drives fetch entries and decode backpressure.
  modport master (
    output in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr
  );
endinterface

// File: rtl/xcore_ifu_ibuf.sv
// Instruction fetch buffer: in-order circular store of {pc, instr} pairs between
// fetch and the IF/ID register, with single-cycle flush on redirect.
module xcore_ifu_ibuf #(
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  xcore_ifu_ibuf_if.slave          bus,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  // Handshakes depend only on registered state and reset, never on the peer's
  // valid/ready, so there is no combinational in-to-out path. A full buffer
  // stays not-ready even when decode pops in the same cycle.
  assign bus.in_ready  = (count_q != CW'(DEPTH)) & ~reset;
  assign bus.out_valid = (count_q != '0);
  assign bus.out_pc    = mem_q[rd_ptr_q].pc;
  assign bus.out_instr = mem_q[rd_ptr_q].instr;
  assign count         = count_q;

  assign push = bus.in_valid  & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  // Next pointer/occupancy; flush wins over push and pop, dropping the entry
  // fetch believes was accepted.
  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path
    // through this block leaves one unassigned, which would infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State register and storage write; reset overrides everything.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values, independent of statement order.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      // NOTE: storage is cleared on reset because out_pc/out_instr are defined
      // to read zero afterwards; a plain FIFO would leave the array unreset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push && !flush) mem_q[wr_ptr_q] <= '{pc: bus.in_pc, instr: bus.in_instr};
    end
  end
endmodule

// File: tb/tb_xcore_ifu_ibuf.sv
// Self-checking bench for xcore_ifu_ibuf: a per-cycle vector table for the
// directed sequences plus a queue scoreboard that tracks every accepted entry.
module tb_xcore_ifu_ibuf;
  localparam int DW = 32, AW = 32, DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic [2:0] count;

  xcore_ifu_ibuf_if #(.DW(DW), .AW(AW)) bus ();

  xcore_ifu_ibuf #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus),
    .count (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
  } entry_t;

  typedef struct {
    logic          rst, fl, iv;
    logic [AW-1:0] pc;
    logic          ordy;
    int            exp_count;
    logic          exp_ir, exp_ov, chk_pc;
    logic [AW-1:0] exp_pc;
    logic [DW-1:0] exp_instr;
  } vec_t;

  int     checks = 0;
  int     errors = 0;
  int     pop_cnt = 0;
  bit     mon_en = 1'b0;
  entry_t sb_q[$];
  vec_t   vecs[19];

  function automatic logic [DW-1:0] instr_of(input logic [AW-1:0] pc);
    return {pc[15:0], ~pc[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic fl, input logic iv,
                       input logic [AW-1:0] pc, input logic ordy);
    reset         = rst;
    flush         = fl;
    bus.in_valid  = iv;
    bus.in_pc     = pc;
    bus.in_instr  = instr_of(pc);
    bus.out_ready = ordy;
  endtask

  // Apply current inputs across one rising edge, then settle before checking.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compares head/count/handshakes against the queue model each
  // cycle, then applies the handshakes that will complete at the next edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check("sb_count", 64'(count), 64'(sb_q.size()));
      check("sb_out_valid", 64'(bus.out_valid), 64'(sb_q.size() != 0));
      check("sb_in_ready", 64'(bus.in_ready), 64'((sb_q.size() != DEPTH) && !reset));
      if (bus.out_valid && sb_q.size() != 0) begin
        check("sb_head_pc", 64'(bus.out_pc), 64'(sb_q[0].pc));
        check("sb_head_instr", 64'(bus.out_instr), 64'(sb_q[0].instr));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) check("sb_pop_empty", 64'(1), 64'(0));
        else void'(sb_q.pop_front());
        pop_cnt++;
      end
      if (bus.in_valid && bus.in_ready)
        sb_q.push_back('{pc: bus.in_pc, instr: bus.in_instr});
      if (reset || flush) sb_q.delete();
    end
  end

  initial begin
    int base;
    //          rst   fl    iv    pc          ordy  cnt ir    ov    chkpc pc          instr
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,     1'b0, 0,  1'b0, 1'b0, 1'b1, 32'h0,     32'h0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,     1'b0, 0,  1'b0, 1'b0, 1'b1, 32'h0,     32'h0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'h100,   1'b0, 1,  1'b1, 1'b1, 1'b1, 32'h100,   instr_of(32'h100)};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'h104,   1'b0, 2,  1'b1, 1'b1, 1'b1, 32'h100,   instr_of(32'h100)};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h108,   1'b0, 3,  1'b1, 1'b1, 1'b1, 32'h100,   instr_of(32'h100)};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'h10C,   1'b0, 4,  1'b0, 1'b1, 1'b1, 32'h100,   instr_of(32'h100)};
    // full: push offered with pop -> only the pop happens
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'h110,   1'b1, 3,  1'b1, 1'b1, 1'b1, 32'h104,   instr_of(32'h104)};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 3,  1'b1, 1'b1, 1'b1, 32'h104,   instr_of(32'h104)};
    // flush with push and pop in the same cycle
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 32'h114,   1'b1, 0,  1'b1, 1'b0, 1'b0, 32'h0,     32'h0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h200,   1'b0, 1,  1'b1, 1'b1, 1'b1, 32'h200,   instr_of(32'h200)};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h204,   1'b0, 2,  1'b1, 1'b1, 1'b1, 32'h200,   instr_of(32'h200)};
    // backpressure for 5 cycles at count=2
    for (int i = 11; i <= 15; i++)
      vecs[i] = '{1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 2,  1'b1, 1'b1, 1'b1, 32'h200,   instr_of(32'h200)};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 32'h208,   1'b0, 3,  1'b1, 1'b1, 1'b1, 32'h200,   instr_of(32'h200)};
    // reset mid-operation with a push offered
    vecs[17] = '{1'b1, 1'b0, 1'b1, 32'h20C,   1'b0, 0,  1'b0, 1'b0, 1'b1, 32'h0,     32'h0};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 0,  1'b1, 1'b0, 1'b1, 32'h0,     32'h0};

    drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].pc, vecs[i].ordy);
      if (i == 17) begin
        #1;
        check("v17_in_ready_in_reset", 64'(bus.in_ready), 64'(0));
      end
      step();
      mon_en = 1'b1;
      check($sformatf("v%0d_count", i), 64'(count), 64'(vecs[i].exp_count));
      check($sformatf("v%0d_in_ready", i), 64'(bus.in_ready), 64'(vecs[i].exp_ir));
      check($sformatf("v%0d_out_valid", i), 64'(bus.out_valid), 64'(vecs[i].exp_ov));
      if (vecs[i].chk_pc) begin
        check($sformatf("v%0d_out_pc", i), 64'(bus.out_pc), 64'(vecs[i].exp_pc));
        check($sformatf("v%0d_out_instr", i), 64'(bus.out_instr), 64'(vecs[i].exp_instr));
      end
    end

    // Streaming with wrap-around: 20 back-to-back pushes, decode always ready.
    base = pop_cnt;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, 1'b1, AW'(4 * i), 1'b1);
      step();
      check($sformatf("stream%0d_count_le1", i), 64'(count <= 1), 64'(1));
    end
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    step();
    check("stream_pops", 64'(pop_cnt - base), 64'(20));
    check("stream_drained", 64'(count), 64'(0));
    check("stream_sb_empty", 64'(sb_q.size()), 64'(0));

    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
